multdiv_ctrl: RTL and testbench

- Sequences the iterative multiply/divide unit for the 5-stage pipeline.
- Detects mul/div in the DX stage and issues a one-cycle start pulse.
- Stalls the front end until the result is written back.
- Arbitrates the register-file write port between normal MW-stage writeback and the multdiv result, including rstatus exception writes.

---
 rtl/multdiv_ctrl.sv | 176 +++++++++++++++++
 tb/tb_multdiv_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_ctrl.sv
// Sequencer for the iterative multiply/divide unit and arbiter for the register-file write port.
// Latency: start pulse in the issue cycle; the write lands one cycle after md_ready, plus one cycle per MW write that blocks it.
// Backpressure: stall holds the front end from RUN until the result owns the write port; MW writes always win the port.
//
// Ports:
//   clock, reset               - rising-edge clock, synchronous active-high reset
//   dx_insn, dx_valid          - instruction in DX, decoded here for mul/div
//   md_result, md_exception,
//   md_ready                   - multdiv completion pulse, result and exception flag
//   ctrl_mult, ctrl_div        - one-cycle start pulses to the multdiv unit
//   mw_data, mw_reg, mw_we     - normal MW-stage writeback request
//   wb_data, wb_reg, wb_we     - arbitrated register-file write port
//   stall, busy                - front-end freeze, operation in flight

module multdiv_ctrl #(
    parameter int LATENCY = 32,
    parameter int TIMEOUT = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] dx_insn,
    input  logic        dx_valid,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    input  logic [31:0] mw_data,
    input  logic [4:0]  mw_reg,
    input  logic        mw_we,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_reg,
    output logic        wb_we,
    output logic        stall,
    output logic        busy
);

    // Counter must hold the timeout threshold; it is also wide enough to
    // observe a nominal-latency completion should TIMEOUT ever be set below it.
    localparam int CNT_MAX = (TIMEOUT > LATENCY) ? TIMEOUT : LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_WB_PEND = 2'd2;

    // Exception writes go to rstatus with a code per operation kind.
    localparam logic [4:0]  RSTATUS_REG = 5'd30;
    localparam logic [31:0] EXC_MUL     = 32'd4;
    localparam logic [31:0] EXC_DIV     = 32'd5;

    localparam logic [4:0] OPC_ALU    = 5'b00000;
    localparam logic [4:0] ALUOP_MUL  = 5'b00110;
    localparam logic [4:0] ALUOP_DIV  = 5'b00111;

    logic [1:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [4:0]       rd_q,     rd_d;
    logic             op_div_q, op_div_d;
    logic [31:0]      result_q, result_d;
    logic             exc_q,    exc_d;

    logic is_mul;
    logic is_div;
    logic [4:0] dx_rd;

    assign is_mul = dx_valid && (dx_insn[31:27] == OPC_ALU) && (dx_insn[6:2] == ALUOP_MUL);
    assign is_div = dx_valid && (dx_insn[31:27] == OPC_ALU) && (dx_insn[6:2] == ALUOP_DIV);
    assign dx_rd  = dx_insn[26:22];

    // Source/shift fields are irrelevant to sequencing.
    logic unused_insn_bits;
    assign unused_insn_bits = ^{dx_insn[21:7], dx_insn[1:0]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        op_div_d = op_div_q;
        result_d = result_q;
        exc_d    = exc_q;

        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
        stall     = 1'b0;
        busy      = 1'b0;
        // MW owns the write port unless the pending result takes it below.
        wb_data   = mw_data;
        wb_reg    = mw_reg;
        wb_we     = mw_we;

        case (state_q)
            ST_IDLE: begin
                // md_ready is ignored here, including in the issue cycle.
                if (is_mul || is_div) begin
                    ctrl_mult = is_mul;
                    ctrl_div  = is_div;
                    rd_d      = dx_rd;
                    op_div_d  = is_div;
                    cnt_d     = '0;
                    result_d  = '0;
                    exc_d     = 1'b0;
                    state_d   = ST_RUN;
                end
            end

            ST_RUN: begin
                stall = 1'b1;
                busy  = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (md_ready) begin
                    result_d = md_result;
                    exc_d    = md_exception;
                    state_d  = ST_WB_PEND;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Unit never answered: report it as an exception of this op.
                    exc_d   = 1'b1;
                    state_d = ST_WB_PEND;
                end
            end

            ST_WB_PEND: begin
                stall = 1'b1;
                busy  = 1'b1;
                // An MW write is older than the multdiv result, so it goes first
                // and the result waits another cycle.
                if (!mw_we) begin
                    if (exc_q) begin
                        wb_reg  = RSTATUS_REG;
                        wb_data = op_div_q ? EXC_DIV : EXC_MUL;
                        wb_we   = 1'b1;
                    end else begin
                        wb_reg  = rd_q;
                        wb_data = result_q;
                        wb_we   = (rd_q != 5'd0);
                    end
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // All outputs are quiet while reset is held, whatever the inputs say.
        if (reset) begin
            ctrl_mult = 1'b0;
            ctrl_div  = 1'b0;
            stall     = 1'b0;
            busy      = 1'b0;
            wb_data   = '0;
            wb_reg    = '0;
            wb_we     = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rd_q     <= '0;
            op_div_q <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            op_div_q <= op_div_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

endmodule

// File: tb/tb_multdiv_ctrl.sv
module tb_multdiv_ctrl;

    logic        clock;
    logic        reset;
    logic [31:0] dx_insn;
    logic        dx_valid;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_ready;
    logic        ctrl_mult;
    logic        ctrl_div;
    logic [31:0] mw_data;
    logic [4:0]  mw_reg;
    logic        mw_we;
    logic [31:0] wb_data;
    logic [4:0]  wb_reg;
    logic        wb_we;
    logic        stall;
    logic        busy;

    multdiv_ctrl #(.LATENCY(32), .TIMEOUT(40)) dut (
        .clock        (clock),
        .reset        (reset),
        .dx_insn      (dx_insn),
        .dx_valid     (dx_valid),
        .md_result    (md_result),
        .md_exception (md_exception),
        .md_ready     (md_ready),
        .ctrl_mult    (ctrl_mult),
        .ctrl_div     (ctrl_div),
        .mw_data      (mw_data),
        .mw_reg       (mw_reg),
        .mw_we        (mw_we),
        .wb_data      (wb_data),
        .wb_reg       (wb_reg),
        .wb_we        (wb_we),
        .stall        (stall),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          cyc;
        logic        cm;
        logic        cd;
        logic        we;
        logic [4:0]  rg;
        logic [31:0] dt;
        logic        st;
        logic        bz;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: checks the full output vector on every cycle that has an
    // expectation, and flags any start pulse or write nobody predicted.
    always @(negedge clock) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL stale: expectation for cycle %0d not reached in order (now %0d)", e.cyc, cyc);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            total++;
            if ({ctrl_mult, ctrl_div, wb_we, wb_reg, wb_data, stall, busy} !==
                {e.cm, e.cd, e.we, e.rg, e.dt, e.st, e.bz}) begin
                bad++;
                $display("FAIL cyc%0d: got mult=%b div=%b we=%b reg=%0d data=%h stall=%b busy=%b, want mult=%b div=%b we=%b reg=%0d data=%h stall=%b busy=%b",
                         cyc, ctrl_mult, ctrl_div, wb_we, wb_reg, wb_data, stall, busy,
                         e.cm, e.cd, e.we, e.rg, e.dt, e.st, e.bz);
            end
        end else if ((ctrl_mult | ctrl_div | wb_we) !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL unexpected cyc%0d: mult=%b div=%b we=%b reg=%0d data=%h, want no event",
                     cyc, ctrl_mult, ctrl_div, wb_we, wb_reg, wb_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk(input logic [4:0] alu, input logic [4:0] rd);
        return {5'b00000, rd, 5'd2, 5'd3, 5'd0, alu, 2'b00};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) tick();
    endtask

    task automatic push(input int c, input logic cm, input logic cd, input logic we,
                        input logic [4:0] rg, input logic [31:0] dt, input logic st, input logic bz);
        exp_t e;
        e.cyc = c; e.cm = cm; e.cd = cd; e.we = we; e.rg = rg; e.dt = dt; e.st = st; e.bz = bz;
        sb.push_back(e);
    endtask

    // Stalled cycles with no port activity (MW idle).
    task automatic run_span(input int a, input int b);
        for (int k = a; k <= b; k++) push(k, 0, 0, 0, 5'd0, 32'd0, 1, 1);
    endtask

    task automatic zero_at(input int c);
        push(c, 0, 0, 0, 5'd0, 32'd0, 0, 0);
    endtask

    int c0;
    int c1;

    initial begin
        // Reset with a mul in DX and an MW write pending: everything must stay 0.
        reset        = 1'b1;
        dx_insn      = mk(ALU_MUL, 5'd5);
        dx_valid     = 1'b1;
        md_result    = 32'd0;
        md_exception = 1'b0;
        md_ready     = 1'b0;
        mw_we        = 1'b1;
        mw_reg       = 5'd7;
        mw_data      = 32'h11;
        tick();
        zero_at(2);
        zero_at(3);
        wait_cyc(4);
        reset    = 1'b0;
        dx_valid = 1'b0;
        mw_we    = 1'b0;
        mw_reg   = 5'd0;
        mw_data  = 32'd0;
        zero_at(4);
        tick();
        tick();

        // mul $5, result 42 at cycle 32 -> write cycle 33, stall low cycle 34.
        tick();
        c0 = cyc;
        dx_insn  = mk(ALU_MUL, 5'd5);
        dx_valid = 1'b1;
        push(c0, 1, 0, 0, 5'd0, 32'd0, 0, 0);
        run_span(c0 + 1, c0 + 32);
        push(c0 + 33, 0, 0, 1, 5'd5, 32'd42, 1, 1);
        zero_at(c0 + 34);
        tick();
        dx_valid = 1'b0;
        wait_cyc(c0 + 32);
        md_ready  = 1'b1;
        md_result = 32'd42;
        tick();
        md_ready  = 1'b0;
        md_result = 32'd0;
        wait_cyc(c0 + 36);

        // div with exception -> rstatus=5, rd 6 never written.
        c0 = cyc;
        dx_insn  = mk(ALU_DIV, 5'd6);
        dx_valid = 1'b1;
        push(c0, 0, 1, 0, 5'd0, 32'd0, 0, 0);
        run_span(c0 + 1, c0 + 5);
        push(c0 + 6, 0, 0, 1, 5'd30, 32'd5, 1, 1);
        zero_at(c0 + 7);
        tick();
        dx_valid = 1'b0;
        wait_cyc(c0 + 5);
        md_ready     = 1'b1;
        md_exception = 1'b1;
        md_result    = 32'hdead;
        tick();
        md_ready     = 1'b0;
        md_exception = 1'b0;
        md_result    = 32'd0;
        wait_cyc(c0 + 9);

        // WB_PEND blocked by two MW writes, then the multdiv write.
        c0 = cyc;
        dx_insn  = mk(ALU_MUL, 5'd9);
        dx_valid = 1'b1;
        push(c0, 1, 0, 0, 5'd0, 32'd0, 0, 0);
        run_span(c0 + 1, c0 + 4);
        push(c0 + 5, 0, 0, 1, 5'd7, 32'h11, 1, 1);
        push(c0 + 6, 0, 0, 1, 5'd7, 32'h11, 1, 1);
        push(c0 + 7, 0, 0, 1, 5'd9, 32'h99, 1, 1);
        zero_at(c0 + 8);
        tick();
        dx_valid = 1'b0;
        wait_cyc(c0 + 4);
        md_ready  = 1'b1;
        md_result = 32'h99;
        tick();
        md_ready  = 1'b0;
        md_result = 32'd0;
        mw_we     = 1'b1;
        mw_reg    = 5'd7;
        mw_data   = 32'h11;
        tick();
        tick();
        mw_we     = 1'b0;
        mw_reg    = 5'd0;
        mw_data   = 32'd0;
        wait_cyc(c0 + 10);

        // Timeout: no md_ready, mul -> rstatus=4 at cycle 41.
        c0 = cyc;
        dx_insn  = mk(ALU_MUL, 5'd4);
        dx_valid = 1'b1;
        push(c0, 1, 0, 0, 5'd0, 32'd0, 0, 0);
        run_span(c0 + 1, c0 + 40);
        push(c0 + 41, 0, 0, 1, 5'd30, 32'd4, 1, 1);
        zero_at(c0 + 42);
        tick();
        dx_valid = 1'b0;
        wait_cyc(c0 + 44);

        // Reset at RUN cycle 10; a late md_ready must not write.
        c0 = cyc;
        dx_insn  = mk(ALU_MUL, 5'd8);
        dx_valid = 1'b1;
        push(c0, 1, 0, 0, 5'd0, 32'd0, 0, 0);
        run_span(c0 + 1, c0 + 9);
        zero_at(c0 + 10);
        zero_at(c0 + 11);
        zero_at(c0 + 16);
        tick();
        dx_valid = 1'b0;
        wait_cyc(c0 + 10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_cyc(c0 + 15);
        md_ready  = 1'b1;
        md_result = 32'h77;
        tick();
        md_ready  = 1'b0;
        md_result = 32'd0;
        wait_cyc(c0 + 18);

        // Fresh mul after the abandoned one.
        c1 = cyc;
        dx_insn  = mk(ALU_MUL, 5'd3);
        dx_valid = 1'b1;
        push(c1, 1, 0, 0, 5'd0, 32'd0, 0, 0);
        run_span(c1 + 1, c1 + 3);
        push(c1 + 4, 0, 0, 1, 5'd3, 32'd123, 1, 1);
        zero_at(c1 + 5);
        tick();
        dx_valid = 1'b0;
        wait_cyc(c1 + 3);
        md_ready  = 1'b1;
        md_result = 32'd123;
        tick();
        md_ready  = 1'b0;
        md_result = 32'd0;
        wait_cyc(c1 + 7);

        // Back-to-back: mul rd=0 (no write), div held in DX issues on first IDLE cycle.
        c0 = cyc;
        dx_insn  = mk(ALU_MUL, 5'd0);
        dx_valid = 1'b1;
        push(c0, 1, 0, 0, 5'd0, 32'd0, 0, 0);
        run_span(c0 + 1, c0 + 3);
        push(c0 + 4, 0, 0, 0, 5'd0, 32'd55, 1, 1);
        push(c0 + 5, 0, 1, 0, 5'd0, 32'd0, 0, 0);
        run_span(c0 + 6, c0 + 8);
        push(c0 + 9, 0, 0, 1, 5'd12, 32'd77, 1, 1);
        zero_at(c0 + 10);
        tick();
        dx_insn = mk(ALU_DIV, 5'd12);
        wait_cyc(c0 + 3);
        md_ready  = 1'b1;
        md_result = 32'd55;
        tick();
        md_ready  = 1'b0;
        md_result = 32'd0;
        tick();
        tick();
        dx_valid = 1'b0;
        wait_cyc(c0 + 8);
        md_ready  = 1'b1;
        md_result = 32'd77;
        tick();
        md_ready  = 1'b0;
        md_result = 32'd0;
        wait_cyc(c0 + 14);

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL leftover: %0d expectations unchecked, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
